// File: rtl/cache_block_set_associative.sv
// Set-associative, read-only block cache with a single outstanding line
// fetch, lowest-invalid / round-robin victim selection and saturating
// hit/miss counters.
module cache_block_set_associative #(
    parameter int DWIDTH           = 8,
    parameter int SET_BITS         = 2,
    parameter int BLOCK_WIDTH_BITS = 2,
    parameter int WAYS_BITS        = 1,
    parameter int ADDR_IN_WIDTH    = 8
) (
    input  logic                                       clk,
    input  logic                                       rst,
    input  logic                                       flush,
    input  logic                                       addr_in_valid,
    input  logic [ADDR_IN_WIDTH-1:0]                   addr_in,
    output logic                                       addr_in_ready,
    output logic [DWIDTH-1:0]                          data_out,
    output logic                                       data_out_valid,
    output logic                                       addr_out_valid,
    output logic [ADDR_IN_WIDTH-BLOCK_WIDTH_BITS-1:0]  addr_out,
    input  logic                                       addr_out_ready,
    input  logic [DWIDTH*(2**BLOCK_WIDTH_BITS)-1:0]    data_in,
    output logic [31:0]                                hit_count,
    output logic [31:0]                                miss_count
);

    localparam int TAG_WIDTH = ADDR_IN_WIDTH - SET_BITS - BLOCK_WIDTH_BITS;
    localparam int NUM_SETS  = 2 ** SET_BITS;
    localparam int NUM_WAYS  = 2 ** WAYS_BITS;
    localparam int WORDS     = 2 ** BLOCK_WIDTH_BITS;
    localparam int WB        = (WAYS_BITS > 0) ? WAYS_BITS : 1;

    typedef enum logic {S_IDLE, S_FETCH} state_t;

    state_t state_q, state_d;

    logic [WORDS-1:0][DWIDTH-1:0] lines [NUM_SETS][NUM_WAYS];
    logic [TAG_WIDTH-1:0]         tags  [NUM_SETS][NUM_WAYS];
    logic [NUM_WAYS-1:0]          valid [NUM_SETS];
    logic [WB-1:0]                rr    [NUM_SETS];

    logic [TAG_WIDTH-1:0]        req_tag, cap_tag;
    logic [SET_BITS-1:0]         req_set, cap_set;
    logic [BLOCK_WIDTH_BITS-1:0] req_word, cap_word;
    logic [WORDS-1:0][DWIDTH-1:0] fill_words;

    logic          hit, all_valid, victim_found;
    logic [WB-1:0] hit_way, victim;
    logic          miss_evt, fill_evt, refill_q;

    assign req_tag    = addr_in[ADDR_IN_WIDTH-1 -: TAG_WIDTH];
    assign req_set    = addr_in[BLOCK_WIDTH_BITS +: SET_BITS];
    assign req_word   = addr_in[BLOCK_WIDTH_BITS-1:0];
    assign fill_words = data_in;

    assign addr_out_valid = (state_q == S_FETCH);
    assign addr_out       = {cap_tag, cap_set};

    // Tag compare across all ways of the addressed set; lowest way wins.
    always_comb begin
        hit     = 1'b0;
        hit_way = '0;
        for (int unsigned w = 0; w < NUM_WAYS; w++) begin
            if (!hit && valid[req_set][w] && tags[req_set][w] == req_tag) begin
                hit     = 1'b1;
                hit_way = WB'(w);
            end
        end
    end

    // Victim for the captured set: lowest invalid way, else round-robin pointer.
    always_comb begin
        victim       = rr[cap_set];
        victim_found = 1'b0;
        for (int unsigned w = 0; w < NUM_WAYS; w++) begin
            if (!victim_found && !valid[cap_set][w]) begin
                victim       = WB'(w);
                victim_found = 1'b1;
            end
        end
        all_valid = !victim_found;
    end

    // Next-state and request handshake decode.
    always_comb begin
        state_d       = state_q;
        addr_in_ready = 1'b0;
        miss_evt      = 1'b0;
        fill_evt      = 1'b0;
        if (!rst) begin
            case (state_q)
                S_IDLE: begin
                    if (addr_in_valid && !flush) begin
                        if (hit) begin
                            addr_in_ready = 1'b1;
                        end else begin
                            miss_evt = 1'b1;
                            state_d  = S_FETCH;
                        end
                    end
                end
                S_FETCH: begin
                    if (addr_out_ready) begin
                        fill_evt = 1'b1;
                        state_d  = S_IDLE;
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    // State, valid bits, pointers, response and counters.
    // The acceptance in the cycle after a refill is the re-lookup of the
    // request just served from data_in, so it neither re-issues data nor counts.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q        <= S_IDLE;
            refill_q       <= 1'b0;
            data_out       <= '0;
            data_out_valid <= 1'b0;
            hit_count      <= '0;
            miss_count     <= '0;
            for (int unsigned s = 0; s < NUM_SETS; s++) begin
                valid[s] <= '0;
                rr[s]    <= '0;
            end
        end else begin
            state_q        <= state_d;
            refill_q       <= fill_evt;
            data_out_valid <= 1'b0;
            if (addr_in_ready && !refill_q) begin
                data_out       <= lines[req_set][hit_way][req_word];
                data_out_valid <= 1'b1;
                if (hit_count != '1) hit_count <= hit_count + 32'd1;
            end
            if (miss_evt) begin
                cap_tag  <= req_tag;
                cap_set  <= req_set;
                cap_word <= req_word;
                if (miss_count != '1) miss_count <= miss_count + 32'd1;
            end
            if (fill_evt) begin
                data_out                <= fill_words[cap_word];
                data_out_valid          <= 1'b1;
                valid[cap_set][victim]  <= 1'b1;
                if (all_valid && NUM_WAYS > 1) rr[cap_set] <= rr[cap_set] + WB'(1);
            end
            if (flush && state_q == S_IDLE) begin
                for (int unsigned s = 0; s < NUM_SETS; s++) begin
                    valid[s] <= '0;
                    rr[s]    <= '0;
                end
            end
        end
    end

    // Line data and tag storage; written only on refill, never reset.
    always_ff @(posedge clk) begin
        if (fill_evt) begin
            lines[cap_set][victim] <= fill_words;
            tags[cap_set][victim]  <= cap_tag;
        end
    end

endmodule

// File: tb/tb_cache_block_set_associative.sv
// Directed testbench for cache_block_set_associative with default parameters.
module tb_cache_block_set_associative;

    logic        clk = 1'b0;
    logic        rst, flush, addr_in_valid, addr_out_ready;
    logic [7:0]  addr_in;
    logic        addr_in_ready, data_out_valid, addr_out_valid;
    logic [7:0]  data_out;
    logic [5:0]  addr_out;
    logic [31:0] data_in, hit_count, miss_count;

    int errors = 0;
    int checks = 0;

    cache_block_set_associative #(
        .DWIDTH(8), .SET_BITS(2), .BLOCK_WIDTH_BITS(2), .WAYS_BITS(1), .ADDR_IN_WIDTH(8)
    ) dut (
        .clk(clk), .rst(rst), .flush(flush),
        .addr_in_valid(addr_in_valid), .addr_in(addr_in), .addr_in_ready(addr_in_ready),
        .data_out(data_out), .data_out_valid(data_out_valid),
        .addr_out_valid(addr_out_valid), .addr_out(addr_out),
        .addr_out_ready(addr_out_ready), .data_in(data_in),
        .hit_count(hit_count), .miss_count(miss_count)
    );

    always #5 clk = ~clk;

    // Stimulus-only helper: miss on addr a, fill one cycle later, drop request
    // after the refill/re-lookup cycle. Starts and ends just after a negedge.
    task automatic fill(input logic [7:0] a, input logic [31:0] line);
        addr_in_valid = 1'b1; addr_in = a;
        @(negedge clk);
        addr_out_ready = 1'b1; data_in = line;
        @(negedge clk);
        addr_out_ready = 1'b0;
        @(negedge clk);
        addr_in_valid = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1; flush = 1'b0; addr_in_valid = 1'b0; addr_in = '0;
        addr_out_ready = 1'b0; data_in = '0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        #1;
        checks++; if (data_out_valid !== 1'b0) begin errors++; $display("FAIL reset_dov: got %b want 0", data_out_valid); end
        checks++; if (data_out !== 8'h00) begin errors++; $display("FAIL reset_dout: got %h want 00", data_out); end
        checks++; if (addr_out_valid !== 1'b0) begin errors++; $display("FAIL reset_aov: got %b want 0", addr_out_valid); end
        checks++; if (hit_count !== 32'd0 || miss_count !== 32'd0) begin errors++; $display("FAIL reset_cnt: got %0d/%0d want 0/0", hit_count, miss_count); end
    endtask

    task automatic test_miss_fill();
        addr_in_valid = 1'b1; addr_in = 8'h13; #1;
        checks++; if (addr_in_ready !== 1'b0) begin errors++; $display("FAIL miss_ready: got %b want 0", addr_in_ready); end
        @(negedge clk);
        checks++; if (addr_out_valid !== 1'b1 || addr_out !== 6'h04) begin errors++; $display("FAIL fetch1: got aov=%b addr=%h want 1/04", addr_out_valid, addr_out); end
        checks++; if (miss_count !== 32'd1) begin errors++; $display("FAIL miss_cnt1: got %0d want 1", miss_count); end
        @(negedge clk);
        checks++; if (addr_out_valid !== 1'b1 || addr_out !== 6'h04) begin errors++; $display("FAIL fetch2_hold: got aov=%b addr=%h want 1/04", addr_out_valid, addr_out); end
        addr_out_ready = 1'b1; data_in = 32'h44332211;
        @(negedge clk);
        addr_out_ready = 1'b0;
        checks++; if (data_out_valid !== 1'b1 || data_out !== 8'h44) begin errors++; $display("FAIL fill_data: got dov=%b dout=%h want 1/44", data_out_valid, data_out); end
        checks++; if (addr_in_ready !== 1'b1 || addr_out_valid !== 1'b0) begin errors++; $display("FAIL fill_relookup: got rdy=%b aov=%b want 1/0", addr_in_ready, addr_out_valid); end
        @(negedge clk);
        addr_in_valid = 1'b0;
        checks++; if (data_out_valid !== 1'b0 || hit_count !== 32'd0) begin errors++; $display("FAIL refill_nocount: got dov=%b hits=%0d want 0/0", data_out_valid, hit_count); end
    endtask

    task automatic test_back_to_back();
        logic [7:0] exp_data [3];
        exp_data[0] = 8'h11; exp_data[1] = 8'h22; exp_data[2] = 8'h33;
        for (int i = 0; i < 3; i++) begin
            addr_in_valid = 1'b1; addr_in = 8'h10 + 8'(i); #1;
            checks++; if (addr_in_ready !== 1'b1) begin errors++; $display("FAIL b2b_ready%0d: got %b want 1", i, addr_in_ready); end
            @(negedge clk);
            checks++; if (data_out_valid !== 1'b1 || data_out !== exp_data[i]) begin errors++; $display("FAIL b2b_data%0d: got dov=%b dout=%h want 1/%h", i, data_out_valid, data_out, exp_data[i]); end
            if (i == 0) begin
                checks++; if (hit_count !== 32'd1) begin errors++; $display("FAIL hit_cnt1: got %0d want 1", hit_count); end
            end
        end
        addr_in_valid = 1'b0;
        @(negedge clk);
        checks++; if (data_out_valid !== 1'b0 || hit_count !== 32'd3) begin errors++; $display("FAIL b2b_end: got dov=%b hits=%0d want 0/3", data_out_valid, hit_count); end
    endtask

    task automatic test_replacement();
        do_reset();
        fill(8'h03, 32'hA3A2A1A0);
        fill(8'h13, 32'hB3B2B1B0);
        addr_in_valid = 1'b1; addr_in = 8'h23; #1;
        checks++; if (addr_in_ready !== 1'b0) begin errors++; $display("FAIL repl_23_miss: got %b want 0", addr_in_ready); end
        fill(8'h23, 32'hC3C2C1C0);
        addr_in_valid = 1'b1; addr_in = 8'h13; #1;
        checks++; if (addr_in_ready !== 1'b1) begin errors++; $display("FAIL repl_13_hit: got %b want 1", addr_in_ready); end
        @(negedge clk);
        checks++; if (data_out !== 8'hB3) begin errors++; $display("FAIL repl_13_data: got %h want b3", data_out); end
        addr_in = 8'h03; #1;
        checks++; if (addr_in_ready !== 1'b0) begin errors++; $display("FAIL repl_03_evicted: got %b want 0", addr_in_ready); end
        fill(8'h03, 32'hD3D2D1D0);
        addr_in_valid = 1'b1; addr_in = 8'h13; #1;
        checks++; if (addr_in_ready !== 1'b0) begin errors++; $display("FAIL repl_way1_evicted: got %b want 0", addr_in_ready); end
        addr_in = 8'h23; #1;
        checks++; if (addr_in_ready !== 1'b1) begin errors++; $display("FAIL repl_23_kept: got %b want 1", addr_in_ready); end
        @(negedge clk);
        checks++; if (data_out !== 8'hC3) begin errors++; $display("FAIL repl_23_data: got %h want c3", data_out); end
        addr_in = 8'h00; #1;
        @(negedge clk);
        addr_in_valid = 1'b0;
        checks++; if (data_out !== 8'hD0) begin errors++; $display("FAIL repl_03_new: got %h want d0", data_out); end
        checks++; if (miss_count !== 32'd4 || hit_count !== 32'd3) begin errors++; $display("FAIL repl_cnt: got m=%0d h=%0d want 4/3", miss_count, hit_count); end
    endtask

    task automatic test_flush();
        do_reset();
        fill(8'h13, 32'h44332211);
        addr_in_valid = 1'b1; addr_in = 8'h13; flush = 1'b1; #1;
        checks++; if (addr_in_ready !== 1'b0) begin errors++; $display("FAIL flush_block: got %b want 0", addr_in_ready); end
        @(negedge clk);
        flush = 1'b0; #1;
        checks++; if (addr_in_ready !== 1'b0 || data_out_valid !== 1'b0) begin errors++; $display("FAIL flush_cleared: got rdy=%b dov=%b want 0/0", addr_in_ready, data_out_valid); end
        @(negedge clk);
        checks++; if (addr_out_valid !== 1'b1 || addr_out !== 6'h04 || miss_count !== 32'd2) begin errors++; $display("FAIL flush_refetch: got aov=%b addr=%h m=%0d want 1/04/2", addr_out_valid, addr_out, miss_count); end
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        checks++; if (addr_out_valid !== 1'b1) begin errors++; $display("FAIL flush_in_fetch: got aov=%b want 1", addr_out_valid); end
        addr_out_ready = 1'b1; data_in = 32'h88776655;
        @(negedge clk);
        addr_out_ready = 1'b0;
        checks++; if (data_out_valid !== 1'b1 || data_out !== 8'h88) begin errors++; $display("FAIL flush_fill: got dov=%b dout=%h want 1/88", data_out_valid, data_out); end
        @(negedge clk);
        addr_in = 8'h10; #1;
        checks++; if (addr_in_ready !== 1'b1) begin errors++; $display("FAIL flush_fetch_kept: got %b want 1", addr_in_ready); end
        @(negedge clk);
        addr_in_valid = 1'b0;
        checks++; if (data_out !== 8'h55) begin errors++; $display("FAIL flush_hit_data: got %h want 55", data_out); end
    endtask

    task automatic test_reset_in_fetch();
        do_reset();
        fill(8'h13, 32'h44332211);
        addr_in_valid = 1'b1; addr_in = 8'h23; addr_out_ready = 1'b1; data_in = 32'hFFFFFFFF;
        @(negedge clk);
        addr_out_ready = 1'b0;
        checks++; if (addr_out_valid !== 1'b1 || addr_out !== 6'h08) begin errors++; $display("FAIL aor_idle_ignored: got aov=%b addr=%h want 1/08", addr_out_valid, addr_out); end
        rst = 1'b1; addr_in_valid = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        checks++; if (addr_out_valid !== 1'b0) begin errors++; $display("FAIL rstfetch_aov: got %b want 0", addr_out_valid); end
        checks++; if (hit_count !== 32'd0 || miss_count !== 32'd0) begin errors++; $display("FAIL rstfetch_cnt: got %0d/%0d want 0/0", hit_count, miss_count); end
        addr_in_valid = 1'b1; addr_in = 8'h13; #1;
        checks++; if (addr_in_ready !== 1'b0) begin errors++; $display("FAIL rstfetch_13_miss: got %b want 0", addr_in_ready); end
        @(negedge clk);
        checks++; if (addr_out_valid !== 1'b1 || miss_count !== 32'd1) begin errors++; $display("FAIL rstfetch_refetch: got aov=%b m=%0d want 1/1", addr_out_valid, miss_count); end
        addr_in_valid = 1'b0;
    endtask

    task automatic test_saturation();
        do_reset();
        force dut.miss_count = 32'hFFFF_FFFE;
        #1;
        release dut.miss_count;
        #1;
        checks++; if (miss_count !== 32'hFFFF_FFFE) begin errors++; $display("FAIL sat_preload: got %h want fffffffe", miss_count); end
        fill(8'h13, 32'h44332211);
        checks++; if (miss_count !== 32'hFFFF_FFFF) begin errors++; $display("FAIL sat_reach: got %h want ffffffff", miss_count); end
        fill(8'h23, 32'h44332211);
        checks++; if (miss_count !== 32'hFFFF_FFFF) begin errors++; $display("FAIL sat_hold: got %h want ffffffff", miss_count); end
    endtask

    initial begin
        @(negedge clk);
        test_reset();
        test_miss_fill();
        test_back_to_back();
        test_replacement();
        test_flush();
        test_reset_in_fetch();
        test_saturation();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/cache_block_set_associative.md
CACHE_BLOCK_SET_ASSOCIATIVE -- requirements
Module: cache_block_set_associative

Interface
REQ-001 Parameter DWIDTH, default 8, SHALL be the data word width in bits.
REQ-002 Parameter SET_BITS, default 2, SHALL be log2 of the number of sets.
REQ-003 Parameter BLOCK_WIDTH_BITS, default 2, SHALL be log2 of the words per line.
REQ-004 Parameter WAYS_BITS, default 1, SHALL be log2 of the ways per set (0 = direct mapped).
REQ-005 Parameter ADDR_IN_WIDTH, default 8, SHALL be the word address width; TAG_WIDTH = ADDR_IN_WIDTH-SET_BITS-BLOCK_WIDTH_BITS, which SHALL be at least 1.
REQ-006 clk  in  1  clock; all state SHALL update on its rising edge.
REQ-007 rst  in  1  reset, synchronous, active-high.
REQ-008 flush  in  1  invalidate all lines.
REQ-009 addr_in_valid  in  1  request present.
REQ-010 addr_in  in  ADDR_IN_WIDTH  word address {tag,set,word}.
REQ-011 addr_in_ready  out  1  request accepted this cycle.
REQ-012 data_out  out  DWIDTH  response word.
REQ-013 data_out_valid  out  1  data_out valid, one-cycle pulse.
REQ-014 addr_out_valid  out  1  line fetch request.
REQ-015 addr_out  out  ADDR_IN_WIDTH-BLOCK_WIDTH_BITS  line address {tag,set}.
REQ-016 addr_out_ready  in  1  line fetch done; data_in valid this cycle.
REQ-017 data_in  in  DWIDTH*2**BLOCK_WIDTH_BITS  line; word i at bits [i*DWIDTH +: DWIDTH].
REQ-018 hit_count, miss_count  out  32 each  saturating event counters.

Function
REQ-019 States SHALL be S_IDLE and S_FETCH only.
REQ-020 S_IDLE: addr_in_ready SHALL equal addr_in_valid && !flush && hit, with hit combinational across all ways of the addressed set (valid && tag match).
REQ-021 A hit SHALL drive data_out_valid=1 with the addressed word in the next cycle (latency 1); back-to-back hits SHALL be accepted every cycle.
REQ-022 S_IDLE miss (addr_in_valid && !flush && !hit): tag, set, and word SHALL be captured, and the state SHALL move to S_FETCH; addr_in_ready SHALL stay 0.
REQ-023 S_FETCH: addr_out_valid SHALL be 1 and addr_out SHALL be the captured {tag,set}, held stable until addr_out_ready.
REQ-024 S_FETCH with addr_out_ready=1: data_in SHALL be written to the victim way, its tag and valid bit SHALL be set, and the state SHALL return to S_IDLE. In the next cycle data_out_valid SHALL be 1 and data_out SHALL be the captured word, taken from data_in. That cycle SHALL also be the original request's addr_in_ready pulse, issued as a hit on re-lookup.
REQ-025 Victim SHALL be the lowest-index invalid way of the set; if all ways are valid, the victim SHALL be the set's round-robin pointer, which then increments modulo 2**WAYS_BITS.
REQ-026 hit_count SHALL increment once per hit-accepted request not caused by a refill; miss_count SHALL increment once per S_IDLE->S_FETCH transition. Both SHALL saturate at 0xFFFFFFFF.
REQ-027 flush in S_IDLE SHALL clear all valid bits and round-robin pointers in one cycle and SHALL block acceptance that cycle.
REQ-028 flush in S_FETCH SHALL be ignored.
REQ-029 Simultaneous hit on multiple ways cannot occur by construction; the lowest-index way SHALL win if it does.
REQ-030 addr_out_ready outside S_FETCH SHALL be ignored.

Reset
REQ-031 rst SHALL force S_IDLE, clear all valid bits, round-robin pointers and counters, and set addr_in_ready, data_out_valid, addr_out_valid = 0 and data_out = 0.
REQ-032 rst during S_FETCH SHALL abandon the fetch, and addr_out_valid SHALL be 0 in the following cycle.
REQ-033 Line contents SHALL NOT require reset.

Verification
REQ-034 After reset, request 0x13; addr_out_ready=1 on the 2nd fetch cycle with data_in=0x44332211 -> addr_out=0x04, miss_count=1, next cycle after fill data_out=0x44 with data_out_valid=1.
REQ-035 Then request 0x10 -> addr_in_ready=1 the same cycle, data_out=0x11 one cycle later, hit_count=1.
REQ-036 Requests 0x03, 0x13, 0x23, each filled -> the third evicts way 0 (tag 0). Then 0x13 -> hit; 0x03 -> miss and evicts way 1.
REQ-037 Fill 0x13, then flush=1 for one cycle, then request 0x13 -> miss, addr_out_valid=1, miss_count incremented.
REQ-038 rst asserted while in S_FETCH with addr_out_valid=1 -> addr_out_valid=0 next cycle, counters=0, and 0x13 misses afterwards.
REQ-039 miss_count preloaded near 0xFFFFFFFF via repeated misses (or force) -> value holds at 0xFFFFFFFF with no wrap.
